// File: rtl/fetch_pc_gen_if.sv
// Fetch PC generator bus: predecode/BTB/redirect inputs and the PC outputs.
// The master modport is the fetch front end that drives the control inputs.
// The slave modport is fetch_pc_gen itself.
interface fetch_pc_gen_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int FETCH_WIDTH = 2
);
    localparam int SLOT_WIDTH = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;

    logic                  stall;
    logic                  redirectValid;
    logic [ADDR_WIDTH-1:0] redirectPc;
    logic                  ctrlValid;
    logic [SLOT_WIDTH-1:0] ctrlSlot;
    logic                  ctrlIsCall;
    logic                  ctrlIsReturn;
    logic                  ctrlTaken;
    logic                  btbHit;
    logic [ADDR_WIDTH-1:0] btbPredictedPc;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] npc;
    logic                  rasEmpty;

    modport master (
        output stall, redirectValid, redirectPc, ctrlValid, ctrlSlot,
               ctrlIsCall, ctrlIsReturn, ctrlTaken, btbHit, btbPredictedPc,
        input  pc, npc, rasEmpty
    );

    modport slave (
        input  stall, redirectValid, redirectPc, ctrlValid, ctrlSlot,
               ctrlIsCall, ctrlIsReturn, ctrlTaken, btbHit, btbPredictedPc,
        output pc, npc, rasEmpty
    );
endinterface

// File: rtl/fetch_pc_gen.sv
// Fetch-stage PC generator: fetch PC register, next fetch-group address
// selection and an optional return-address stack.
// Configuration macro: FETCH_PC_RAS_EN (defined -> RAS present; undefined ->
// no RAS, returns follow the BTB path and rasEmpty is tied high).
module fetch_pc_gen #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    FETCH_WIDTH = 2,
    parameter int                    RAS_DEPTH   = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input logic            clk,
    input logic            rst,
    fetch_pc_gen_if.slave  bus
);
    localparam logic [ADDR_WIDTH-1:0] GROUP_BYTES = ADDR_WIDTH'(4 * FETCH_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] GROUP_MASK  = ~ADDR_WIDTH'(4 * FETCH_WIDTH - 1);

    if (!(FETCH_WIDTH == 1 || FETCH_WIDTH == 2 || FETCH_WIDTH == 4)) begin : g_bad_fetch_width
        $error("fetch_pc_gen: FETCH_WIDTH must be 1, 2 or 4");
    end
    if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_ras_depth
        $error("fetch_pc_gen: RAS_DEPTH must be a power of 2 and at least 2");
    end
    if ((RESET_PC & ~GROUP_MASK) != '0) begin : g_bad_reset_pc
        $error("fetch_pc_gen: RESET_PC must be fetch-group aligned");
    end

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0] seq;
    logic [ADDR_WIDTH-1:0] npc_c;
    logic [ADDR_WIDTH-1:0] ras_top;
    logic                  ras_hit;
    logic                  ras_empty;

    // Low redirect bits are discarded by construction.
    logic unused_redirect_bits;
    assign unused_redirect_bits = ^bus.redirectPc[1:0];

    assign base = pc_q & GROUP_MASK;
    assign seq  = base + GROUP_BYTES;

`ifdef FETCH_PC_RAS_EN
    localparam int PTR_W   = $clog2(RAS_DEPTH);
    localparam int COUNT_W = $clog2(RAS_DEPTH + 1);

    // ptr_q points at the next free slot; the top of stack is ptr_q-1.
    logic [ADDR_WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]      ptr_q,   ptr_n;
    logic [COUNT_W-1:0]    count_q, count_n;
    logic                  empty_q;
    logic                  wr_en;
    logic [PTR_W-1:0]      wr_addr;
    logic [ADDR_WIDTH-1:0] link;
    logic                  ras_update;
    logic                  do_pop;
    logic                  do_push;

    assign ras_top    = ras_mem[ptr_q - PTR_W'(1)];
    assign ras_empty  = empty_q;
    assign ras_hit    = bus.ctrlValid && bus.ctrlIsReturn && !empty_q;
    assign link       = base + ((ADDR_WIDTH'(bus.ctrlSlot) + ADDR_WIDTH'(1)) << 2);
    assign ras_update = !bus.redirectValid && !bus.stall && bus.ctrlValid;
    assign do_pop     = ras_update && bus.ctrlIsReturn && (count_q != '0);
    assign do_push    = ras_update && bus.ctrlIsCall;

    // Next RAS pointer/count and write port; call+return replaces the top in place.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        ptr_n   = ptr_q;
        count_n = count_q;
        wr_en   = 1'b0;
        wr_addr = ptr_q;
        if (do_pop && do_push) begin
            wr_en   = 1'b1;
            wr_addr = ptr_q - PTR_W'(1);
        end else if (do_pop) begin
            ptr_n   = ptr_q - PTR_W'(1);
            count_n = count_q - COUNT_W'(1);
        end else if (do_push) begin
            // Pointer wraps, so a push on a full stack overwrites the oldest entry.
            wr_en   = 1'b1;
            ptr_n   = ptr_q + PTR_W'(1);
            if (count_q != COUNT_W'(RAS_DEPTH)) begin
                count_n = count_q + COUNT_W'(1);
            end
        end
    end

    // RAS pointer, occupancy and empty flag.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst) begin
            ptr_q   <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
        end else begin
            ptr_q   <= ptr_n;
            count_q <= count_n;
            empty_q <= (count_n == '0);
        end
    end

    // RAS storage; entries are only ever read while count is non-zero.
    always_ff @(posedge clk) begin
        // NOTE: the array is deliberately not reset; the empty flag guards every read.
        if (rst && wr_en) begin
            ras_mem[wr_addr] <= link;
        end
    end
`else
    assign ras_top   = '0;
    assign ras_hit   = 1'b0;
    assign ras_empty = 1'b1;

    // Call/return hints and the slot index only matter to the RAS.
    logic unused_ras_inputs;
    assign unused_ras_inputs = ^{bus.ctrlIsCall, bus.ctrlIsReturn, bus.ctrlSlot};
`endif

    // Next fetch address in priority order: redirect, stall, RAS, BTB, sequential.
    always_comb begin
        npc_c = seq;
        if (bus.redirectValid) begin
            npc_c = {bus.redirectPc[ADDR_WIDTH-1:2], 2'b00};
        end else if (bus.stall) begin
            npc_c = pc_q;
        end else if (ras_hit) begin
            npc_c = ras_top;
        end else if (bus.ctrlValid && bus.ctrlTaken && bus.btbHit) begin
            npc_c = bus.btbPredictedPc;
        end
    end

    // Fetch PC register; synchronous reset dominates stall and redirect.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= npc_c;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.npc      = npc_c;
    assign bus.rasEmpty = ras_empty;
endmodule

// File: tb/tb_fetch_pc_gen.sv
// Self-checking bench for fetch_pc_gen (FETCH_WIDTH=2, RAS_DEPTH=4, RESET_PC=0x1000).
// Expectations come from a queue-based reference model; expected PCs go
// through a scoreboard queue and are compared after the clock edge.
module tb_fetch_pc_gen;
`ifdef FETCH_PC_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif
    localparam logic [31:0] RESET_PC = 32'h1000;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    logic [31:0] sb[$];

    fetch_pc_gen_if #(.ADDR_WIDTH(32), .FETCH_WIDTH(2)) bif ();

    fetch_pc_gen #(
        .ADDR_WIDTH (32),
        .FETCH_WIDTH(2),
        .RAS_DEPTH  (4),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    always @(posedge clk) begin
        if (rst && bif.ctrlValid) begin
            assert (int'(bif.ctrlSlot) < 2) else $error("illegal ctrlSlot %0d", bif.ctrlSlot);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bif.stall          = 1'b0;
        bif.redirectValid  = 1'b0;
        bif.redirectPc     = '0;
        bif.ctrlValid      = 1'b0;
        bif.ctrlSlot       = '0;
        bif.ctrlIsCall     = 1'b0;
        bif.ctrlIsReturn   = 1'b0;
        bif.ctrlTaken      = 1'b0;
        bif.btbHit         = 1'b0;
        bif.btbPredictedPc = '0;
    endtask

    // One clock: check npc against the model (and optionally a fixed value),
    // queue the expected next pc, then compare pc/rasEmpty after the edge.
    task automatic step(input string tag, input bit pin, input logic [31:0] want);
        logic [31:0] base;
        logic [31:0] exp_npc;
        logic [31:0] link;
        #1;
        base = {m_pc[31:3], 3'b000};
        if (bif.redirectValid)
            exp_npc = {bif.redirectPc[31:2], 2'b00};
        else if (bif.stall)
            exp_npc = m_pc;
        else if (RAS_EN && bif.ctrlValid && bif.ctrlIsReturn && m_ras.size() != 0)
            exp_npc = m_ras[$];
        else if (bif.ctrlValid && bif.ctrlTaken && bif.btbHit)
            exp_npc = bif.btbPredictedPc;
        else
            exp_npc = base + 32'd8;

        if (rst) begin
            check({tag, "_npc"}, bif.npc, exp_npc);
            if (pin) check({tag, "_spec"}, bif.npc, want);
            sb.push_back(exp_npc);
            if (RAS_EN && !bif.redirectValid && !bif.stall && bif.ctrlValid) begin
                link = base + 32'd4 * (32'(bif.ctrlSlot) + 32'd1);
                if (bif.ctrlIsReturn && m_ras.size() != 0) void'(m_ras.pop_back());
                if (bif.ctrlIsCall) begin
                    if (m_ras.size() == 4) void'(m_ras.pop_front());
                    m_ras.push_back(link);
                end
            end
        end else begin
            sb.push_back(RESET_PC);
            m_ras.delete();
        end

        @(posedge clk);
        #1;
        m_pc = sb.pop_front();
        check({tag, "_pc"}, bif.pc, m_pc);
        check({tag, "_empty"}, 32'(bif.rasEmpty), 32'(m_ras.size() == 0));
    endtask

    task automatic redirect_to(input string tag, input logic [31:0] addr);
        idle();
        bif.redirectValid = 1'b1;
        bif.redirectPc    = addr;
        step(tag, 1'b1, {addr[31:2], 2'b00});
        idle();
    endtask

    task automatic ctrl_step(input string tag, input bit call, input bit ret, input logic slot,
                             input logic [31:0] btb, input bit pin, input logic [31:0] want);
        idle();
        bif.ctrlValid      = 1'b1;
        bif.ctrlIsCall     = call;
        bif.ctrlIsReturn   = ret;
        bif.ctrlSlot       = slot;
        bif.ctrlTaken      = 1'b1;
        bif.btbHit         = 1'b1;
        bif.btbPredictedPc = btb;
        step(tag, pin, want);
        idle();
    endtask

    initial begin
        idle();
        m_pc = RESET_PC;

        // 1. Reset and sequential fetch, then reset mid-stream.
        rst = 1'b0;
        step("t1_rst", 1'b0, '0);
        check("t1_reset_pc", bif.pc, 32'h1000);
        check("t1_reset_empty", 32'(bif.rasEmpty), 32'd1);
        rst = 1'b1;
        step("t1_seq0", 1'b1, 32'h1008);
        step("t1_seq1", 1'b1, 32'h1010);
        step("t1_seq2", 1'b1, 32'h1018);
        check("t1_pc_1018", bif.pc, 32'h1018);
        rst = 1'b0;
        bif.stall = 1'b1;
        bif.redirectValid = 1'b1;
        bif.redirectPc = 32'h7777;
        step("t1_midrst", 1'b0, '0);
        check("t1_midrst_pc", bif.pc, 32'h1000);
        idle();
        rst = 1'b1;

        // 2. Unaligned-in-group pc and address wrap.
        redirect_to("t2_go2004", 32'h2004);
        step("t2_unaligned", 1'b1, 32'h2008);
        redirect_to("t2_gowrap", 32'hFFFF_FFF8);
        step("t2_wrap", 1'b1, 32'h0000_0000);

        // 3. Redirect overrides stall; stall holds pc.
        bif.stall = 1'b1;
        bif.redirectValid = 1'b1;
        bif.redirectPc = 32'h3003;
        step("t3_stall_redir", 1'b1, 32'h3000);
        idle();
        bif.stall = 1'b1;
        for (int i = 0; i < 3; i++) step($sformatf("t3_hold%0d", i), 1'b1, 32'h3000);
        idle();

        // 4. Call then matching return.
        redirect_to("t4_go4000", 32'h4000);
        ctrl_step("t4_call", 1'b1, 1'b0, 1'b1, 32'h5000, 1'b1, 32'h5000);
        step("t4_seq0", 1'b1, 32'h5008);
        step("t4_seq1", 1'b1, 32'h5010);
        ctrl_step("t4_ret", 1'b0, 1'b1, 1'b0, 32'h7777_0000, 1'b1,
                  RAS_EN ? 32'h4008 : 32'h7777_0000);
        check("t4_empty_after", 32'(bif.rasEmpty), 32'd1);

        // 5. Overflow: five calls into a 4-deep stack, then five returns.
        for (int i = 1; i <= 5; i++) begin
            redirect_to($sformatf("t5_go%0d", i), 32'(i) * 32'h100);
            ctrl_step($sformatf("t5_call%0d", i), 1'b1, 1'b0, 1'b0, 32'h8000, 1'b1, 32'h8000);
        end
        for (int i = 5; i >= 1; i--) begin
            redirect_to($sformatf("t5_gor%0d", i), 32'h9000);
            ctrl_step($sformatf("t5_ret%0d", i), 1'b0, 1'b1, 1'b0, 32'hA000, 1'b1,
                      (RAS_EN && i > 1) ? 32'(i) * 32'h100 + 32'h4 : 32'hA000);
        end
        check("t5_empty_after", 32'(bif.rasEmpty), 32'd1);

        // 6. Linked call+return replaces the top of stack.
        redirect_to("t6_go8ff8", 32'h8FF8);
        ctrl_step("t6_push9000", 1'b1, 1'b0, 1'b1, 32'hC000, 1'b1, 32'hC000);
        redirect_to("t6_go6000", 32'h6000);
        ctrl_step("t6_callret", 1'b1, 1'b1, 1'b0, 32'hB000, 1'b1,
                  RAS_EN ? 32'h9000 : 32'hB000);
        check("t6_not_empty", 32'(bif.rasEmpty), RAS_EN ? 32'd0 : 32'd1);
        redirect_to("t6_goret", 32'hD000);
        ctrl_step("t6_ret", 1'b0, 1'b1, 1'b0, 32'hE000, 1'b1,
                  RAS_EN ? 32'h6004 : 32'hE000);

        // 7. Reset clears the stack; a following return takes the BTB path.
        ctrl_step("t7_call", 1'b1, 1'b0, 1'b0, 32'hF000, 1'b0, '0);
        rst = 1'b0;
        step("t7_rst", 1'b0, '0);
        rst = 1'b1;
        ctrl_step("t7_ret", 1'b0, 1'b1, 1'b0, 32'hF100, 1'b1, 32'hF100);

        // 8. Call with no BTB hit goes sequential but still pushes.
        redirect_to("t8_go", 32'h2000);
        idle();
        bif.ctrlValid  = 1'b1;
        bif.ctrlIsCall = 1'b1;
        bif.ctrlSlot   = 1'b1;
        step("t8_call_seq", 1'b1, 32'h2008);
        idle();
        ctrl_step("t8_ret", 1'b0, 1'b1, 1'b0, 32'h3300, 1'b1,
                  RAS_EN ? 32'h2008 : 32'h3300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
